// File: rtl/dma_pkg.sv
// Shared types and register-map constants for the multi-channel DMA engine.
package dma_pkg;

    // Engine sequencing: one word per pass through ARB..NEXT.
    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StRdReq,
        StRdWait,
        StWrReq,
        StNext
    } dma_state_e;

    // Per-channel register offsets, selected by addr[1:0].
    localparam logic [1:0] RegCtrl = 2'd0;
    localparam logic [1:0] RegSrc  = 2'd1;
    localparam logic [1:0] RegDst  = 2'd2;
    localparam logic [1:0] RegLen  = 2'd3;

    // Global status register, addr[5:0] with all higher bits zero.
    localparam logic [5:0] StatusAddr = 6'h20;

    // CTRL bit positions.
    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlIrqEnBit = 1;

    // DONE field starts at this bit of STATUS; BUSY starts at bit 0.
    localparam int unsigned StatusDoneLsb = 8;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin channel picker; the pointer names the highest-priority channel.
module dma_rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] gnt
);

    logic [2:0] ptr_q, ptr_d;
    logic       found;
    int         idx;

    // Scan from the pointer, wrapping, and grant the first requester.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // On advance, the channel after the one just granted becomes top priority.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (gnt[i]) begin
                    ptr_d = (i == NUM_CH - 1) ? 3'd0 : 3'(i + 1);
                end
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dma_mc_engine.sv
// Multi-channel memory-to-memory DMA: register file, word-interleaved engine, irq.
module dma_mc_engine
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  irq
);

    logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] src_d [NUM_CH];
    logic [ADDR_WIDTH-1:0] dst_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] dst_d [NUM_CH];
    logic [LEN_WIDTH-1:0]  len_q [NUM_CH];
    logic [LEN_WIDTH-1:0]  len_d [NUM_CH];
    logic [NUM_CH-1:0]     irq_en_q, irq_en_d;
    logic [NUM_CH-1:0]     busy_q, busy_d;
    logic [NUM_CH-1:0]     done_q, done_d;

    dma_state_e            st_q, st_d;
    logic [2:0]            cur_q, cur_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rd_val;
    logic                  irq_q;

    logic [ADDR_WIDTH-1:0] cur_src, cur_dst;
    logic [NUM_CH-1:0]     arb_gnt;
    logic [2:0]            gnt_idx;
    logic                  arb_adv;

    logic                  hi_zero, ch_space, status_hit;
    logic [2:0]            addr_ch;
    logic [1:0]            addr_reg;
    logic                  unused_wdata;

    assign hi_zero    = (addr[ADDR_WIDTH-1:6] == '0);
    assign ch_space   = hi_zero && !addr[5];
    assign status_hit = hi_zero && (addr[5:0] == StatusAddr);
    assign addr_ch    = addr[4:2];
    assign addr_reg   = addr[1:0];

    // Only low bits of wdata land in registers; the rest is deliberately dropped.
    assign unused_wdata = ^wdata;

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (busy_q),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

    // One-hot grant to channel index.
    always_comb begin
        gnt_idx = 3'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (arb_gnt[c]) begin
                gnt_idx = 3'(c);
            end
        end
    end

    // Address/length of the channel currently owned by the engine.
    always_comb begin
        cur_src = '0;
        cur_dst = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cur_q == 3'(c)) begin
                cur_src = src_q[c];
                cur_dst = dst_q[c];
            end
        end
    end

    // Register read mux; out-of-range channels and unmapped addresses return 0.
    always_comb begin
        rd_val = '0;
        if (status_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_val[c]                 = busy_q[c];
                rd_val[StatusDoneLsb + c] = done_q[c];
            end
        end else if (ch_space) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (addr_ch == 3'(c)) begin
                    unique case (addr_reg)
                        RegCtrl: rd_val[CtrlIrqEnBit] = irq_en_q[c];
                        RegSrc:  rd_val = DATA_WIDTH'(src_q[c]);
                        RegDst:  rd_val = DATA_WIDTH'(dst_q[c]);
                        RegLen:  rd_val = DATA_WIDTH'(len_q[c]);
                    endcase
                end
            end
        end
    end

    // Channel register next-state: host writes, START, DONE clear, engine update.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            src_d[c]    = src_q[c];
            dst_d[c]    = dst_q[c];
            len_d[c]    = len_q[c];
            irq_en_d[c] = irq_en_q[c];
            busy_d[c]   = busy_q[c];
            done_d[c]   = done_q[c];

            if (wr_en && ch_space && (addr_ch == 3'(c))) begin
                unique case (addr_reg)
                    RegCtrl: begin
                        irq_en_d[c] = wdata[CtrlIrqEnBit];
                        if (wdata[CtrlStartBit] && !busy_q[c]) begin
                            // Zero-length start completes immediately with no traffic.
                            if (len_q[c] != '0) begin
                                busy_d[c] = 1'b1;
                            end else begin
                                done_d[c] = 1'b1;
                            end
                        end
                    end
                    RegSrc: if (!busy_q[c]) src_d[c] = wdata[ADDR_WIDTH-1:0];
                    RegDst: if (!busy_q[c]) dst_d[c] = wdata[ADDR_WIDTH-1:0];
                    RegLen: if (!busy_q[c]) len_d[c] = wdata[LEN_WIDTH-1:0];
                endcase
            end

            if (wr_en && status_hit && wdata[StatusDoneLsb + c]) begin
                done_d[c] = 1'b0;
            end

            // Engine only touches a busy channel, so host writes never collide here.
            if ((st_q == StNext) && (cur_q == 3'(c))) begin
                src_d[c] = src_q[c] + ADDR_WIDTH'(1);
                dst_d[c] = dst_q[c] + ADDR_WIDTH'(1);
                len_d[c] = len_q[c] - LEN_WIDTH'(1);
                if (len_q[c] == LEN_WIDTH'(1)) begin
                    busy_d[c] = 1'b0;
                    done_d[c] = 1'b1;
                end
            end
        end
    end

    // Engine FSM next-state and memory-port outputs.
    always_comb begin
        st_d      = st_q;
        cur_d     = cur_q;
        data_d    = data_q;
        arb_adv   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (st_q)
            StIdle: begin
                if (|busy_q) st_d = StArb;
            end
            StArb: begin
                if (|busy_q) begin
                    arb_adv = 1'b1;
                    cur_d   = gnt_idx;
                    st_d    = StRdReq;
                end else begin
                    st_d = StIdle;
                end
            end
            StRdReq: begin
                mem_req  = 1'b1;
                mem_addr = cur_src;
                if (mem_gnt) st_d = StRdWait;
            end
            StRdWait: begin
                if (mem_rvalid) begin
                    data_d = mem_rdata;
                    st_d   = StWrReq;
                end
            end
            StWrReq: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cur_dst;
                mem_wdata = data_q;
                if (mem_gnt) st_d = StNext;
            end
            StNext: begin
                st_d = (|busy_d) ? StArb : StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    // Channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                len_q[c] <= '0;
            end
            irq_en_q <= '0;
            busy_q   <= '0;
            done_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                src_q[c] <= src_d[c];
                dst_q[c] <= dst_d[c];
                len_q[c] <= len_d[c];
            end
            irq_en_q <= irq_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Engine state, current channel and the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= StIdle;
            cur_q  <= 3'd0;
            data_q <= '0;
        end else begin
            st_q   <= st_d;
            cur_q  <= cur_d;
            data_q <= data_d;
        end
    end

    // Registered read data and level interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (rd_en) rdata_q <= rd_val;
            irq_q <= |(done_q & irq_en_q);
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule
